portreq_queue: RTL and testbench

- Per-client request queue that sits directly upstream of the port multiplexer.
- One instance is used per client (IC, MVU, Ctrl). Each instance buffers write requests (address and data) from its client and presents the head request to the multiplexer as csel/addr/data.
- The head entry is retired only in a cycle where the multiplexer returns grant. This decouples clients from arbitration stalls.
- A starvation monitor flags the client when it has been denied for too long.

---
 rtl/portreq_queue_pkg.sv | 17 +
 rtl/portreq_queue_syncfifo.sv | 78 +++++++
 rtl/portreq_queue.sv | 82 ++++++++
 tb/tb_portreq_queue.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/portreq_queue_pkg.sv
// Shared widths and helpers for the port request queue and its multiplexer.
package portreq_queue_pkg;

    localparam int unsigned A_DEF = 9;
    localparam int unsigned W_DEF = 128;

    // Ceiling log2; never returns less than 1 so it can size a vector directly.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/portreq_queue_syncfifo.sv
// Generic synchronous FIFO with registered storage and first-word fall-through read.
module portreq_queue_syncfifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    parameter int unsigned Log2D = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic [Log2D:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [Log2D-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [Log2D:0]   cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (Log2D + 1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next-state for pointers, occupancy and storage; clear wins over push/pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        mem_d  = mem_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = wdata_i;
                wptr_d        = wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is never reset; the caller gates push while in reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/portreq_queue.sv
// Per-client request queue feeding the port multiplexer, with a starvation monitor.
module portreq_queue
    import portreq_queue_pkg::*;
#(
    parameter int unsigned a      = A_DEF,
    parameter int unsigned w      = W_DEF,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LOG2D  = 2,
    parameter int unsigned STARVE = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           inVld,
    output logic           inRdy,
    input  logic [a-1:0]   inAddr,
    input  logic [w-1:0]   inData,
    output logic           csel,
    output logic [a-1:0]   addr,
    output logic [w-1:0]   data,
    input  logic           grnt,
    output logic [LOG2D:0] count,
    output logic           starved
);

    localparam int unsigned SW = clog2(STARVE + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE);

    logic [a+w-1:0] head;
    logic           full, empty, push, pop;
    logic [SW-1:0]  starve_q, starve_d;
    logic           starved_q, starved_d;

    // inRdy deliberately ignores grnt: no combinational grnt->inRdy path.
    assign inRdy = ~rst & ~flush & ~full;
    assign push  = inVld & inRdy;
    assign csel  = ~empty;
    // A grant during flush is consumed upstream but must not pop here.
    assign pop   = csel & grnt & ~flush;

    assign addr    = csel ? head[a+w-1:w] : '0;
    assign data    = csel ? head[w-1:0]   : '0;
    assign starved = starved_q;

    portreq_queue_syncfifo #(
        .Width (a + w),
        .Depth (DEPTH),
        .Log2D (LOG2D)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (flush),
        .push_i  (push),
        .wdata_i ({inAddr, inData}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Count consecutive denied cycles, saturating; any grant, idle or flush clears it.
    always_comb begin
        starve_d = '0;
        if (!flush && csel && !grnt) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
        end
        starved_d = (starve_d == StarveMax);
    end

    // Starvation monitor state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            starved_q <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            starved_q <= starved_d;
        end
    end

endmodule

// File: tb/tb_portreq_queue.sv
// Directed self-checking bench for portreq_queue.
module tb_portreq_queue;

    localparam int A = 9;
    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst, flush, inVld, grnt;
    logic         inRdy, csel, starved;
    logic [A-1:0] inAddr, addr;
    logic [W-1:0] inData, data;
    logic [2:0]   count;

    int n_cmp = 0;
    int n_err = 0;

    portreq_queue dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .inVld   (inVld),
        .inRdy   (inRdy),
        .inAddr  (inAddr),
        .inData  (inData),
        .csel    (csel),
        .addr    (addr),
        .data    (data),
        .grnt    (grnt),
        .count   (count),
        .starved (starved)
    );

    always #5 clk = ~clk;

    // Advance one edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        #1;
        n_cmp++; if (inRdy !== 1'b0) begin n_err++; $display("FAIL rst_inrdy got %b want 0", inRdy); end
        n_cmp++; if (csel !== 1'b0) begin n_err++; $display("FAIL rst_csel got %b want 0", csel); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
        n_cmp++; if (addr !== '0 || data !== '0) begin n_err++; $display("FAIL rst_addrdata got %h/%h want 0", addr, data); end
        n_cmp++; if (starved !== 1'b0) begin n_err++; $display("FAIL rst_starved got %b want 0", starved); end
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if (inRdy !== 1'b1) begin n_err++; $display("FAIL idle_inrdy got %b want 1", inRdy); end
        step();
        n_cmp++; if (csel !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL idle_state csel=%b count=%0d want 0/0", csel, count); end
    endtask

    task automatic test_push_grant();
        inVld = 1'b1; inAddr = 9'h1A5; inData = 128'hDEAD;
        step();
        inVld = 1'b0; grnt = 1'b1;
        n_cmp++; if (csel !== 1'b1 || addr !== 9'h1A5) begin n_err++; $display("FAIL pg_head csel=%b addr=%h want 1/1a5", csel, addr); end
        n_cmp++; if (data !== 128'hDEAD || count !== 3'd1) begin n_err++; $display("FAIL pg_data data=%h count=%0d want dead/1", data, count); end
        step();
        grnt = 1'b0;
        n_cmp++; if (csel !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL pg_drain csel=%b count=%0d want 0/0", csel, count); end
    endtask

    task automatic test_fill_wrap();
        logic [A-1:0] exp_a [$];
        int           exp_d [$];
        int           pushed = 0;
        int           popped = 0;
        for (int i = 0; i < 4; i++) begin
            inVld = 1'b1; inAddr = 9'(16 + pushed); inData = 128'(100 + pushed);
            exp_a.push_back(inAddr); exp_d.push_back(100 + pushed);
            pushed++;
            step();
        end
        inVld = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd4 || inRdy !== 1'b0) begin n_err++; $display("FAIL fill_full count=%0d inRdy=%b want 4/0", count, inRdy); end
        grnt = 1'b1;
        for (int cyc = 0; cyc < 40 && popped < 10; cyc++) begin
            inVld = (pushed < 10);
            inAddr = 9'(16 + pushed); inData = 128'(100 + pushed);
            if (csel) begin
                if (exp_a.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL wrap_spurious got addr=%h want empty", addr);
                end else begin
                    n_cmp++;
                    if (addr !== exp_a[0] || data !== 128'(exp_d[0])) begin
                        n_err++; $display("FAIL wrap_order got %h/%0d want %h/%0d", addr, data, exp_a[0], exp_d[0]);
                    end
                    void'(exp_a.pop_front()); void'(exp_d.pop_front());
                    popped++;
                end
            end
            if (inVld && inRdy) begin
                exp_a.push_back(inAddr); exp_d.push_back(100 + pushed);
                pushed++;
            end
            step();
            n_cmp++; if (count > 3'd4) begin n_err++; $display("FAIL wrap_count got %0d want <=4", count); end
        end
        inVld = 1'b0; grnt = 1'b0;
        n_cmp++; if (popped !== 10) begin n_err++; $display("FAIL wrap_total got %0d want 10", popped); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL wrap_empty got %0d want 0", count); end
    endtask

    task automatic test_push_pop_one();
        inVld = 1'b1; inAddr = 9'h0A1; inData = 128'h1;
        step();
        inAddr = 9'h0B2; inData = 128'h2; grnt = 1'b1;
        n_cmp++; if (addr !== 9'h0A1 || count !== 3'd1) begin n_err++; $display("FAIL pp_pre addr=%h count=%0d want 0a1/1", addr, count); end
        step();
        inVld = 1'b0;
        n_cmp++; if (count !== 3'd1 || addr !== 9'h0B2 || data !== 128'h2) begin n_err++; $display("FAIL pp_post count=%0d addr=%h want 1/0b2", count, addr); end
        step();
        grnt = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL pp_drain got %0d want 0", count); end
    endtask

    task automatic test_starve();
        inVld = 1'b1; inAddr = 9'h155; inData = 128'h55;
        step();
        inVld = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_cmp++;
            if (starved !== (k >= 15)) begin n_err++; $display("FAIL starve_k%0d got %b want %b", k, starved, (k >= 15)); end
        end
        grnt = 1'b1;
        step();
        grnt = 1'b0;
        n_cmp++; if (starved !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL starve_clear starved=%b count=%0d want 0/0", starved, count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            inVld = 1'b1; inAddr = 9'(32 + i); inData = 128'(i);
            step();
        end
        inVld = 1'b0;
        step(); step();
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL fl_pre got %0d want 3", count); end
        flush = 1'b1; inVld = 1'b1; inAddr = 9'h1FF; grnt = 1'b1;
        #1;
        n_cmp++; if (inRdy !== 1'b0) begin n_err++; $display("FAIL fl_inrdy got %b want 0", inRdy); end
        step();
        flush = 1'b0; inVld = 1'b0; grnt = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0 || csel !== 1'b0) begin n_err++; $display("FAIL fl_state count=%0d csel=%b want 0/0", count, csel); end
        n_cmp++; if (addr !== '0 || starved !== 1'b0 || inRdy !== 1'b1) begin n_err++; $display("FAIL fl_out addr=%h starved=%b inRdy=%b want 0/0/1", addr, starved, inRdy); end
        // Counter must start from zero: starved rises after exactly 15 denials.
        inVld = 1'b1; inAddr = 9'h077; inData = 128'h77;
        step();
        inVld = 1'b0;
        for (int k = 0; k < 14; k++) step();
        n_cmp++; if (starved !== 1'b0 || addr !== 9'h077) begin n_err++; $display("FAIL fl_cnt14 starved=%b addr=%h want 0/077", starved, addr); end
        step();
        n_cmp++; if (starved !== 1'b1) begin n_err++; $display("FAIL fl_cnt15 got %b want 1", starved); end
        grnt = 1'b1;
        step();
        grnt = 1'b0;
        // rst together with flush yields the reset state.
        for (int i = 0; i < 2; i++) begin
            inVld = 1'b1; inAddr = 9'(48 + i); inData = 128'(i);
            step();
        end
        inVld = 1'b0; rst = 1'b1; flush = 1'b1;
        #1;
        n_cmp++; if (inRdy !== 1'b0) begin n_err++; $display("FAIL rf_inrdy got %b want 0", inRdy); end
        step();
        n_cmp++; if (count !== 3'd0 || csel !== 1'b0 || starved !== 1'b0) begin n_err++; $display("FAIL rf_state count=%0d csel=%b starved=%b want 0", count, csel, starved); end
        rst = 1'b0; flush = 1'b0;
        #1;
        n_cmp++; if (inRdy !== 1'b1) begin n_err++; $display("FAIL rf_release got %b want 1", inRdy); end
        step();
        n_cmp++; if (count !== 3'd0 || data !== '0) begin n_err++; $display("FAIL rf_idle count=%0d data=%h want 0", count, data); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; inVld = 1'b0; grnt = 1'b0;
        inAddr = '0; inData = '0;
        test_reset();
        test_push_grant();
        test_fill_wrap();
        test_push_pop_one();
        test_starve();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
